// File: rtl/apb_resp_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_resp_pkg;

  // Width of the access-phase wait counter; holds WAIT_CYCLES values 0..15.
  localparam int WAIT_W = 4;

  // Transfer phase as seen by the completer.
  typedef enum logic {
    APB_IDLE   = 1'b0,
    APB_ACCESS = 1'b1
  } apb_state_e;

endpackage : apb_resp_pkg

// File: rtl/apb_resp_mem.sv
// DEPTH x DATA_W register storage with per-byte write enables, asynchronous
// clear and a combinational read port.
module apb_resp_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  // DEPTH may not be a power of two, so indices above DEPTH-1 read as zero.
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every register on reset; otherwise merge the strobed bytes.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Combinational read, zero for indices past the end of the array.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < DEPTH_L) begin
      rd_data = mem[rd_idx];
    end
  end

endmodule : apb_resp_mem

// File: rtl/apb_regfile_responder.sv
// APB completer fronting a byte-strobed register file, with a fixed number
// of access-phase wait states and an error response for out-of-range indices.
module apb_regfile_responder
  import apb_resp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  // Handshake: a transfer opens with a setup cycle (psel=1, penable=0) and
  // continues with access cycles (psel=1, penable=1). The requester must hold
  // psel, penable, pwrite, paddr, pwdata and pstrb stable through the access
  // phase; the transfer completes (and commits) on the edge ending the cycle
  // in which pready is high. pready is only ever raised in the access phase,
  // after WAIT_CYCLES stalled access cycles. pslverr and prdata are
  // meaningful only while pready is high and are forced to zero otherwise.

  // Current phase; kept as a named register so checkers can observe it.
  apb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  logic              in_range;
  logic              done;
  logic              mem_wr_en;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range = ({1'b0, paddr} < DEPTH_A);
  assign mem_idx  = paddr[IDX_W-1:0];

  // Phase and wait-counter registers, both cleared asynchronously.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase, wait countdown and the completion strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (psel && !penable) begin
          state_d = APB_ACCESS;
          cnt_d   = WAIT_INIT;
        end
      end
      APB_ACCESS: begin
        if (!psel) begin
          // Requester walked away: drop the transfer without committing.
          state_d = APB_IDLE;
          cnt_d   = '0;
        end else if (!penable) begin
          // A fresh setup cycle restarts the wait from the top.
          cnt_d = WAIT_INIT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = APB_IDLE;
        end
      end
      default: begin
        state_d = APB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Response muxing; only in-range writes reach the storage.
  always_comb begin
    pready    = done;
    pslverr   = done && !in_range;
    prdata    = '0;
    mem_wr_en = done && pwrite && in_range;
    if (done && !pwrite && in_range) begin
      prdata = mem_rdata;
    end
  end

  apb_resp_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_mem (
    .pclk    (pclk),
    .prst    (prst),
    .wr_en   (mem_wr_en),
    .wr_idx  (mem_idx),
    .wr_strb (pstrb),
    .wr_data (pwdata),
    .rd_idx  (mem_idx),
    .rd_data (mem_rdata)
  );

endmodule : apb_regfile_responder

// File: tb/tb_apb_regfile_responder.sv
// Bench for apb_regfile_responder: one instance with two wait states and one
// with none, sharing a single APB bus whose psel is steered by tgt.
module tb_apb_regfile_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int STRB_W = DATA_W / 8;
  localparam int WAITS [2] = '{2, 0};

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  logic              psel    = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite  = 1'b0;
  logic [ADDR_W-1:0] paddr   = '0;
  logic [DATA_W-1:0] pwdata  = '0;
  logic [STRB_W-1:0] pstrb   = '0;
  int                tgt     = 0;

  logic psel_a, psel_b;
  assign psel_a = psel && (tgt == 0);
  assign psel_b = psel && (tgt == 1);

  logic              pready_a, pslverr_a, pready_b, pslverr_b;
  logic [DATA_W-1:0] prdata_a, prdata_b;

  apb_regfile_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .pclk(pclk), .prst(prst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a)
  );

  apb_regfile_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .pclk(pclk), .prst(prst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cur_pready(input int k);
    return (k == 0) ? pready_a : pready_b;
  endfunction

  function automatic logic cur_pslverr(input int k);
    return (k == 0) ? pslverr_a : pslverr_b;
  endfunction

  function automatic logic [DATA_W-1:0] cur_prdata(input int k);
    return (k == 0) ? prdata_a : prdata_b;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // Transaction-level view: each target has a register array, a flag saying
  // a transfer is open, and how many access cycles it has already waited.
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  bit                m_open [2];
  int                m_waited [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_open[k]   = 1'b0;
      m_waited[k] = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
    end
  end

  always @(negedge pclk) begin
    for (int k = 0; k < 2; k++) begin
      logic              sel_k;
      logic              e_rdy, e_err;
      logic [DATA_W-1:0] e_dat, mask;
      sel_k = psel && (tgt == k);
      e_rdy = 1'b0;
      e_err = 1'b0;
      e_dat = '0;
      if (prst) begin
        m_open[k] = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
      end else if (m_open[k]) begin
        if (!sel_k) begin
          m_open[k] = 1'b0;
        end else if (!penable) begin
          m_waited[k] = 0;
        end else if (m_waited[k] < WAITS[k]) begin
          m_waited[k] = m_waited[k] + 1;
        end else begin
          e_rdy     = 1'b1;
          e_err     = (int'(paddr) >= DEPTH);
          m_open[k] = 1'b0;
          if (!e_err) begin
            if (pwrite) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (pstrb[b]) begin
                  mask = 32'hFF << (8 * b);
                  m_mem[k][paddr[3:0]] = (m_mem[k][paddr[3:0]] & ~mask) | (pwdata & mask);
                end
              end
            end else begin
              e_dat = m_mem[k][paddr[3:0]];
            end
          end
        end
      end else if (sel_k && !penable) begin
        m_open[k]   = 1'b1;
        m_waited[k] = 0;
      end
      check($sformatf("cyc_pready%0d", k), 32'(cur_pready(k)), 32'(e_rdy));
      check($sformatf("cyc_pslverr%0d", k), 32'(cur_pslverr(k)), 32'(e_err));
      check($sformatf("cyc_prdata%0d", k), cur_prdata(k), e_dat);
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic xfer(input int k, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                      output logic [DATA_W-1:0] rd, output logic err, output int lat);
    bit got;
    got = 1'b0;
    rd  = '0;
    err = 1'b0;
    lat = 0;
    tgt = k; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge pclk);
      if (cur_pready(k)) begin
        rd  = cur_prdata(k);
        err = cur_pslverr(k);
        got = 1'b1;
        break;
      end
      lat++;
      @(posedge pclk); #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no pready from target %0d addr %0d within 40 cycles", k, a);
    end else begin
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_write(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [STRB_W-1:0] s, input logic exp_err);
    logic [DATA_W-1:0] rd;
    logic err;
    int lat;
    xfer(k, 1'b1, a, d, s, rd, err, lat);
    check($sformatf("wr_err%0d_a%0d", k, a), 32'(err), 32'(exp_err));
    check($sformatf("wr_lat%0d_a%0d", k, a), 32'(lat), 32'(WAITS[k]));
  endtask

  task automatic do_read(input int k, input logic [ADDR_W-1:0] a, input logic exp_err);
    logic [DATA_W-1:0] rd, exp;
    logic err;
    int lat;
    xfer(k, 1'b0, a, '0, '0, rd, err, lat);
    exp = '0;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else $display("bench note: expected queue empty at read of addr %0d", a);
    check($sformatf("rd_data%0d_a%0d", k, a), rd, exp);
    check($sformatf("rd_err%0d_a%0d", k, a), 32'(err), 32'(exp_err));
    check($sformatf("rd_lat%0d_a%0d", k, a), 32'(lat), 32'(WAITS[k]));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    @(negedge pclk);
    check("rst_pready_a", 32'(pready_a), 32'd0);
    check("rst_prdata_a", prdata_a, 32'd0);
    check("rst_pslverr_a", 32'(pslverr_a), 32'd0);
    check("rst_pready_b", 32'(pready_b), 32'd0);
    @(posedge pclk); #1;
    prst = 1'b0;
    @(posedge pclk); #1;

    // Full-word write and read-back, two wait states.
    do_write(0, 8'd3, 32'hDEADBEEF, 4'hF, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    do_read(0, 8'd3, 1'b0);

    // Partial write: bytes 0 and 2 replaced.
    do_write(0, 8'd7, 32'h11223344, 4'hF, 1'b0);
    do_write(0, 8'd7, 32'hAAAAAAAA, 4'b0101, 1'b0);
    exp_q.push_back(32'h11AA33AA);
    do_read(0, 8'd7, 1'b0);

    // Zero strobe is a harmless no-op write.
    do_write(0, 8'd3, 32'h00000000, 4'h0, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    do_read(0, 8'd3, 1'b0);

    // Out of range: error on write and read, read data zero.
    do_write(0, 8'd20, 32'h12345678, 4'hF, 1'b1);
    exp_q.push_back(32'h0);
    do_read(0, 8'd20, 1'b1);
    exp_q.push_back(32'h0);
    do_read(0, 8'd255, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back((i == 3) ? 32'hDEADBEEF : (i == 7) ? 32'h11AA33AA : 32'h0);
      do_read(0, 8'(i), 1'b0);
    end

    // Abort during the second access cycle: nothing committed.
    tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5;
    pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort_pready_t1", 32'(pready_a), 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("abort_pready_t2", 32'(pready_a), 32'd0);
    @(posedge pclk); #1;
    exp_q.push_back(32'h0);
    do_read(0, 8'd5, 1'b0);

    // Reset in the very cycle a read of idx 9 is completing.
    do_write(0, 8'd9, 32'hCAFEF00D, 4'hF, 1'b0);
    tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'd9;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    check("prerst_pready", 32'(pready_a), 32'd1);
    check("prerst_prdata", prdata_a, 32'hCAFEF00D);
    prst = 1'b1;
    #1;
    check("midrst_pready", 32'(pready_a), 32'd0);
    check("midrst_prdata", prdata_a, 32'd0);
    check("midrst_pslverr", 32'(pslverr_a), 32'd0);
    @(posedge pclk); #1;
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    exp_q.push_back(32'h0);
    do_read(0, 8'd9, 1'b0);
    exp_q.push_back(32'h0);
    do_read(0, 8'd3, 1'b0);

    // Zero wait states, back-to-back transfers.
    do_write(1, 8'd0, 32'h01020304, 4'hF, 1'b0);
    do_write(1, 8'd1, 32'hA5A5A5A5, 4'hF, 1'b0);
    do_write(1, 8'd2, 32'hFFFF0000, 4'b1100, 1'b0);
    exp_q.push_back(32'h01020304);
    do_read(1, 8'd0, 1'b0);
    exp_q.push_back(32'hA5A5A5A5);
    do_read(1, 8'd1, 1'b0);
    exp_q.push_back(32'hFFFF0000);
    do_read(1, 8'd2, 1'b0);
    exp_q.push_back(32'h0);
    do_read(1, 8'd16, 1'b1);

    repeat (2) @(posedge pclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_apb_regfile_responder
